mm_arbiter: RTL and testbench
=============================

MM_ARBITER -- requirements
Module: mm_arbiter

Interface
REQ-001 clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 req0, req1  in  1 each  access request from port 0 (CPU) and port 1 (DMA/debug master).
REQ-004 we0, we1  in  1 each  1 = write, 0 = read, per port.
REQ-005 addr0, addr1  in  16 each  memory-mapped address, per port.
REQ-006 wdata0, wdata1  in  16 each  write data, per port.
REQ-007 gnt0, gnt1  out  1 each  port currently owns the bus.
REQ-008 ack0, ack1  out  1 each  one-cycle completion pulse, per port.
REQ-009 rdata_out  out  16  read data returned to the owning port; valid while its ack is high.
REQ-010 err  out  1  transaction timed out; valid while ack is high.
REQ-011 mm_re, mm_we  out  1 each  peripheral-side read and write strobes.
REQ-012 addr, wdata  out  16 each  peripheral-side address and write data.
REQ-013 rdata  in  16  peripheral read data.
REQ-014 rdy  in  1  peripheral completion, sampled while the bus is busy.

Function
REQ-015 FSM SHALL have three states: IDLE, BUS, ACK.
REQ-016 In IDLE, on an edge with req0 or req1 high, the FSM SHALL select a winner, latch that port's we, addr and wdata into the peripheral registers, and go to BUS.
REQ-017 Arbitration SHALL be round-robin: with a single requester, that port wins; with both requesting, the port not granted last wins.
REQ-018 The last-grant pointer SHALL update only on a grant.
REQ-019 In BUS, mm_re SHALL be high for reads and mm_we high for writes, never both, and addr and wdata SHALL be held stable.
REQ-020 In IDLE and ACK, mm_re, mm_we, addr and wdata SHALL all be 0.
REQ-021 gnt of the winner SHALL be high throughout BUS and ACK; at most one gnt SHALL be high in any cycle.
REQ-022 When rdy is sampled high in BUS, the block SHALL capture rdata (reads) or 16'h0000 (writes) into rdata_out, clear err, and go to ACK.
REQ-023 A 4-bit wait counter SHALL clear on entry to BUS and increment for each BUS cycle with rdy low.
REQ-024 When the wait counter reaches 15 with rdy still low, the block SHALL go to ACK with err=1 and rdata_out=16'hFFFF; the peripheral strobes SHALL drop at that point.
REQ-025 ACK SHALL last exactly one cycle with the owner's ack high, then return to IDLE; requests SHALL NOT be sampled during ACK.
REQ-026 Latency: req seen at edge k; strobes high after edge k; with rdy high at edge k+1, ack is high after edge k+1. Minimum is 3 cycles per transaction.
REQ-027 Requesters SHALL hold req and their operands until ack. Deassertion of req during BUS SHALL NOT abort the transaction.
REQ-028 Operand changes by the owner after grant SHALL NOT affect the latched transaction.
REQ-029 rdy in IDLE or ACK SHALL be ignored.

Reset
REQ-030 Asserting rst_n low SHALL immediately force: state IDLE, pointer to port 0 preferred, wait counter 0, and every output to 0, including mid-transaction. No ack SHALL be issued for an aborted transaction.
REQ-031 After rst_n is released, the first edge SHALL evaluate arbitration normally.

Structure
REQ-032 State encoding, TIMEOUT_CYCLES=15 and ERR_DATA=16'hFFFF SHALL live in a shared package.
REQ-033 Winner selection SHALL be a sub-module rr_arb2 (req0, req1, last-grant pointer -> one-hot grant). The FSM, counter and datapath registers SHALL be in mm_arbiter.

Verification
REQ-034 Test: req0 read, addr0=16'h2004, rdy=1 on the first BUS cycle, rdata=16'h00A5. Required: mm_re for 1 cycle with addr=16'h2004; ack0 pulses with rdata_out=16'h00A5 and err=0; 3 cycles in total.
REQ-035 Test: req0 and req1 both held continuously from reset, rdy=1. Required: grants alternate 0,1,0,1, never overlapping, with each ack on the correct port.
REQ-036 Test: req1 write, addr1=16'h4000, wdata1=16'hBEEF, rdy held low. Required: mm_we high for exactly 15 BUS cycles; ack1 with err=1 and rdata_out=16'hFFFF; then IDLE.
REQ-037 Test: rst_n pulsed low during BUS of a port-0 read. Required: all outputs 0 asynchronously, no ack0; the next request is granted normally.
REQ-038 Test: addr0 changed to 16'h6000 and req0 dropped one cycle after grant, rdy after 3 cycles. Required: addr stays at the original value; ack0 still issued.

Source files
------------

// File: rtl/mm_arbiter_pkg.sv
// Shared types and constants for the two-port memory-mapped bus arbiter.
package mm_arbiter_pkg;
  localparam int              DATA_W         = 16;
  localparam logic [3:0]      TIMEOUT_CYCLES = 4'd15;
  localparam logic [3:0]      TIMEOUT_LAST   = TIMEOUT_CYCLES - 4'd1;
  localparam logic [DATA_W-1:0] ERR_DATA     = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } state_t;
endpackage

// File: rtl/mm_arbiter_if.sv
// Peripheral-side bus: strobes, address and write data out, read data and ready back.
interface mm_arbiter_if import mm_arbiter_pkg::*; ();
  logic              mm_re;
  logic              mm_we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdy;

  modport master (output mm_re, mm_we, addr, wdata, input rdata, rdy);
  modport slave  (input mm_re, mm_we, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; last = port granted most recently.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);
  // On contention the port that did not win last time takes the bus.
  assign gnt[0] = req0 & (~req1 | last);
  assign gnt[1] = req1 & (~req0 | ~last);
endmodule

// File: rtl/mm_arbiter.sv
// Arbitrates CPU (port 0) and DMA/debug (port 1) onto one peripheral bus,
// with a bounded wait on the peripheral's rdy.
module mm_arbiter import mm_arbiter_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata_out,
  output logic              err,
  mm_arbiter_if.master      bus
);
  state_t            state;
  logic              last;
  logic [3:0]        wait_cnt;
  logic [1:0]        win;
  logic              sel_we;
  logic [DATA_W-1:0] sel_addr, sel_wdata;

  rr_arb2 u_arb (.req0(req0), .req1(req1), .last(last), .gnt(win));

  always_comb begin
    sel_we    = win[1] ? we1    : we0;
    sel_addr  = win[1] ? addr1  : addr0;
    sel_wdata = win[1] ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      wait_cnt  <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata_out <= '0;
      err       <= 1'b0;
      bus.mm_re <= 1'b0;
      bus.mm_we <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
    end else begin
      case (state)
        IDLE: if (|win) begin
          state     <= BUS;
          last      <= win[1];
          gnt0      <= win[0];
          gnt1      <= win[1];
          wait_cnt  <= '0;
          bus.mm_re <= ~sel_we;
          bus.mm_we <= sel_we;
          bus.addr  <= sel_addr;
          bus.wdata <= sel_wdata;
        end
        BUS: if (bus.rdy || wait_cnt == TIMEOUT_LAST) begin
          // Either completion or the 15th idle wait cycle ends the bus phase.
          state     <= ACK;
          ack0      <= gnt0;
          ack1      <= gnt1;
          err       <= ~bus.rdy;
          rdata_out <= ~bus.rdy ? ERR_DATA
                     : (bus.mm_we ? {DATA_W{1'b0}} : bus.rdata);
          bus.mm_re <= 1'b0;
          bus.mm_we <= 1'b0;
          bus.addr  <= '0;
          bus.wdata <= '0;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
        end
        ACK: begin
          state     <= IDLE;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          rdata_out <= '0;
          err       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_arbiter.sv
// Scenario tests plus randomized transactions checked against a transaction-level model.
module tb_mm_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, ack0, ack1, err;
  logic [15:0] rdata_out;

  mm_arbiter_if bus();

  mm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata_out(rdata_out), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int exp_last = 1;

  // observations from one transaction
  int          m_win, m_re_cyc, m_we_cyc, m_ack_port, m_ack_cyc, m_ack_len;
  logic [15:0] m_addr_first, m_wdata_first, m_rdata, m_exp_rd;
  bit          m_moved, m_both_gnt, m_both_str, m_err, m_idle_after, m_str_at_ack;

  function automatic logic [54:0] outs_now();
    return {gnt0, gnt1, ack0, ack1, err, rdata_out, bus.mm_re, bus.mm_we, bus.addr, bus.wdata};
  endfunction

  task automatic watch(input int rdy_delay, input bit mod_grant, input bit rd_fixed,
                       input logic [15:0] rd_val, input int max_cyc);
    int bus_n, grant_c;
    bit done;
    bus_n = 0; grant_c = -1; done = 0;
    m_win = -1; m_re_cyc = 0; m_we_cyc = 0; m_ack_port = -1; m_ack_cyc = -1; m_ack_len = 0;
    m_addr_first = '0; m_wdata_first = '0; m_rdata = '0; m_exp_rd = '0;
    m_moved = 0; m_both_gnt = 0; m_both_str = 0; m_err = 0; m_idle_after = 0; m_str_at_ack = 0;
    for (int c = 1; c <= max_cyc && !done; c++) begin
      @(posedge clk); #1;
      if (gnt0 && gnt1) m_both_gnt = 1;
      if (bus.mm_re && bus.mm_we) m_both_str = 1;
      if (m_win < 0 && (gnt0 || gnt1)) begin m_win = gnt1 ? 1 : 0; grant_c = c; end
      if (mod_grant && grant_c > 0 && c == grant_c + 1) begin addr0 = 16'h6000; req0 = 0; end
      if (bus.mm_re || bus.mm_we) begin
        bus_n++;
        if (bus_n == 1) begin m_addr_first = bus.addr; m_wdata_first = bus.wdata; end
        else if (bus.addr !== m_addr_first || bus.wdata !== m_wdata_first) m_moved = 1;
        if (bus.mm_re) m_re_cyc++;
        if (bus.mm_we) m_we_cyc++;
        bus.rdy   = (bus_n > rdy_delay);
        bus.rdata = rd_fixed ? rd_val : 16'($urandom);
        if (bus.rdy) m_exp_rd = bus.rdata;
      end else begin
        bus.rdy   = 1'($urandom);
        bus.rdata = 16'($urandom);
      end
      if (ack0 || ack1) begin
        if (m_ack_port < 0) begin
          m_ack_port = ack1 ? 1 : 0; m_ack_cyc = c; m_rdata = rdata_out; m_err = err;
          m_str_at_ack = bus.mm_re | bus.mm_we;
        end
        m_ack_len++;
        if (ack0) req0 = 0;
        if (ack1) req1 = 0;
      end else if (m_ack_port >= 0) begin
        done = 1;
        m_idle_after = !gnt0 && !gnt1 && !bus.mm_re && !bus.mm_we && bus.addr == 0 && bus.wdata == 0;
      end
    end
    bus.rdy = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0; req0 = 0; req1 = 0; bus.rdy = 0;
    @(posedge clk); #1;
    rst_n = 1;
    exp_last = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; bus.rdy = 0; bus.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (outs_now() !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs_now()); end
    rst_n = 1; bus.rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({gnt0, gnt1, bus.mm_re, bus.mm_we} !== 4'b0) begin
      errors++; $display("FAIL idle_ignores_rdy: got %b want 0000", {gnt0, gnt1, bus.mm_re, bus.mm_we}); end
    bus.rdy = 0;
  endtask

  task automatic test_single_read();
    req0 = 1; we0 = 0; addr0 = 16'h2004; wdata0 = 16'h1111; req1 = 0;
    watch(0, 0, 1, 16'h00A5, 10);
    checks++; if (m_win !== 0) begin errors++; $display("FAIL rd_winner: got %0d want 0", m_win); end
    checks++; if (m_re_cyc !== 1 || m_we_cyc !== 0) begin errors++; $display("FAIL rd_strobes: re %0d we %0d want 1 0", m_re_cyc, m_we_cyc); end
    checks++; if (m_addr_first !== 16'h2004) begin errors++; $display("FAIL rd_addr: got %h want 2004", m_addr_first); end
    checks++; if (m_ack_port !== 0) begin errors++; $display("FAIL rd_ack_port: got %0d want 0", m_ack_port); end
    checks++; if (m_rdata !== 16'h00A5 || m_err !== 0) begin errors++; $display("FAIL rd_data: got %h err %b want 00a5 0", m_rdata, m_err); end
    checks++; if (m_ack_cyc !== 2 || m_ack_len !== 1) begin errors++; $display("FAIL rd_latency: ack at %0d len %0d want 2 1", m_ack_cyc, m_ack_len); end
    checks++; if (m_idle_after !== 1 || m_str_at_ack !== 0) begin errors++; $display("FAIL rd_idle: idle %b strobe_at_ack %b want 1 0", m_idle_after, m_str_at_ack); end
    exp_last = 0;
  endtask

  task automatic test_alternate();
    int seq[$];
    bit overlap, bad_ack;
    int last_ack_c;
    rst_n = 0; bus.rdy = 1; bus.rdata = 16'h0042;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0010; addr1 = 16'h0020;
    @(posedge clk); #1;
    rst_n = 1;
    overlap = 0; bad_ack = 0; last_ack_c = -1;
    for (int c = 1; c <= 30 && seq.size() < 4; c++) begin
      @(posedge clk); #1;
      if (gnt0 && gnt1) overlap = 1;
      if ((ack0 && !gnt0) || (ack1 && !gnt1) || (ack0 && ack1)) bad_ack = 1;
      if (ack0 || ack1) begin seq.push_back(ack1 ? 1 : 0); last_ack_c = c; end
    end
    req0 = 0; req1 = 0; bus.rdy = 0;
    @(posedge clk); #1;
    checks++; if (seq.size() !== 4) begin errors++; $display("FAIL alt_count: got %0d acks want 4", seq.size()); end
    else begin
      checks++; if ({seq[0], seq[1], seq[2], seq[3]} !== {32'd0, 32'd1, 32'd0, 32'd1}) begin
        errors++; $display("FAIL alt_order: got %0d %0d %0d %0d want 0 1 0 1", seq[0], seq[1], seq[2], seq[3]); end
    end
    checks++; if (overlap || bad_ack) begin errors++; $display("FAIL alt_overlap: overlap %b bad_ack %b want 0 0", overlap, bad_ack); end
    checks++; if (last_ack_c !== 11) begin errors++; $display("FAIL alt_rate: 4th ack at %0d want 11", last_ack_c); end
    exp_last = 1;
  endtask

  task automatic test_timeout();
    req0 = 0; req1 = 1; we1 = 1; addr1 = 16'h4000; wdata1 = 16'hBEEF;
    watch(1000, 0, 0, '0, 40);
    checks++; if (m_we_cyc !== 15 || m_re_cyc !== 0) begin errors++; $display("FAIL to_strobes: we %0d re %0d want 15 0", m_we_cyc, m_re_cyc); end
    checks++; if (m_addr_first !== 16'h4000 || m_wdata_first !== 16'hBEEF || m_moved) begin
      errors++; $display("FAIL to_operands: addr %h wdata %h moved %b want 4000 beef 0", m_addr_first, m_wdata_first, m_moved); end
    checks++; if (m_ack_port !== 1 || m_err !== 1 || m_rdata !== 16'hFFFF) begin
      errors++; $display("FAIL to_ack: port %0d err %b data %h want 1 1 ffff", m_ack_port, m_err, m_rdata); end
    checks++; if (m_ack_cyc !== 16 || m_idle_after !== 1) begin errors++; $display("FAIL to_timing: ack at %0d idle %b want 16 1", m_ack_cyc, m_idle_after); end
    exp_last = 1;
  endtask

  task automatic test_operand_change();
    req1 = 0; req0 = 1; we0 = 0; addr0 = 16'h1234; wdata0 = 16'h5678;
    watch(3, 1, 1, 16'hC0DE, 20);
    checks++; if (m_addr_first !== 16'h1234 || m_moved) begin errors++; $display("FAIL oc_addr: got %h moved %b want 1234 0", m_addr_first, m_moved); end
    checks++; if (m_re_cyc !== 4) begin errors++; $display("FAIL oc_bus_len: got %0d want 4", m_re_cyc); end
    checks++; if (m_ack_port !== 0 || m_rdata !== 16'hC0DE || m_err !== 0) begin
      errors++; $display("FAIL oc_ack: port %0d data %h err %b want 0 c0de 0", m_ack_port, m_rdata, m_err); end
    exp_last = 0;
  endtask

  task automatic test_reset_mid();
    bit seen, acked;
    req1 = 0; req0 = 1; we0 = 0; addr0 = 16'h3000; seen = 0; acked = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.mm_re) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_grant: got no strobe want mm_re"); end
    bus.rdy = 1;
    #2 rst_n = 0;
    #1;
    checks++; if (outs_now() !== '0) begin errors++; $display("FAIL rm_async: got %h want 0", outs_now()); end
    repeat (2) begin
      @(posedge clk); #1;
      if (ack0 || ack1) acked = 1;
    end
    checks++; if (acked) begin errors++; $display("FAIL rm_no_ack: got ack want none"); end
    bus.rdy = 0; addr0 = 16'h3004;
    rst_n = 1; exp_last = 1;
    watch(1, 0, 0, '0, 10);
    checks++; if (m_win !== 0 || m_ack_port !== 0 || m_addr_first !== 16'h3004 || m_err !== 0) begin
      errors++; $display("FAIL rm_after: win %0d ack %0d addr %h err %b want 0 0 3004 0", m_win, m_ack_port, m_addr_first, m_err); end
    exp_last = 0;
  endtask

  task automatic test_random();
    bit [1:0] r;
    int delay, winner, n;
    bit timeout, w_we;
    logic [15:0] w_addr, w_wdata, e_rd;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(1, 3));
      req0 = r[0]; req1 = r[1];
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = 16'($urandom); addr1 = 16'($urandom);
      wdata0 = 16'($urandom); wdata1 = 16'($urandom);
      delay = $urandom_range(0, 17);
      winner  = (r == 2'b11) ? (exp_last == 1 ? 0 : 1) : (r[1] ? 1 : 0);
      w_we    = winner ? we1 : we0;
      w_addr  = winner ? addr1 : addr0;
      w_wdata = winner ? wdata1 : wdata0;
      timeout = (delay >= 15);
      n = timeout ? 15 : delay + 1;
      watch(delay, 0, 0, '0, 30);
      e_rd = timeout ? 16'hFFFF : (w_we ? 16'h0000 : m_exp_rd);
      checks++; if (m_win !== winner || m_ack_port !== winner) begin
        errors++; $display("FAIL rnd_port[%0d]: win %0d ack %0d want %0d", i, m_win, m_ack_port, winner); end
      checks++; if (m_re_cyc !== (w_we ? 0 : n) || m_we_cyc !== (w_we ? n : 0)) begin
        errors++; $display("FAIL rnd_strobes[%0d]: re %0d we %0d want we=%b n=%0d", i, m_re_cyc, m_we_cyc, w_we, n); end
      checks++; if (m_addr_first !== w_addr || m_wdata_first !== w_wdata || m_moved) begin
        errors++; $display("FAIL rnd_operands[%0d]: %h %h moved %b want %h %h", i, m_addr_first, m_wdata_first, m_moved, w_addr, w_wdata); end
      checks++; if (m_rdata !== e_rd || m_err !== timeout) begin
        errors++; $display("FAIL rnd_result[%0d]: data %h err %b want %h %b", i, m_rdata, m_err, e_rd, timeout); end
      checks++; if (m_both_gnt || m_both_str || m_ack_len !== 1 || m_ack_cyc !== n + 1 || !m_idle_after) begin
        errors++; $display("FAIL rnd_protocol[%0d]: gg %b ss %b len %0d ack_at %0d idle %b want ack_at %0d",
                           i, m_both_gnt, m_both_str, m_ack_len, m_ack_cyc, m_idle_after, n + 1); end
      exp_last = winner;
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_timeout();
    test_operand_change();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
